arm_fetch: RTL and testbench
============================

Name: arm_fetch

Overview:
Instruction fetch stage directly upstream of arm_decode. It owns the program counter, issues word reads to instruction memory over a req/ack handshake, and holds the fetched word in an instruction register. It also evaluates the ARM condition field against the CPSR flags to drive inst and cond_pass into the decode unit. Redirects (branches, PC writes) arrive from the register-file/writeback side via pc_we/pc_in.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request; held high until imem_ack
imem_addr  output  32  word-aligned fetch address; stable while imem_req high
imem_ack  input  1  one-cycle pulse: imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
inst  output  32  held instruction to arm_decode
inst_valid  output  1  inst holds a live, unsquashed instruction
cond_pass  output  1  condition check result for inst (0 when inst_valid=0)
decode_ready  input  1  decode consumes inst this cycle when inst_valid=1
pc_we  input  1  redirect request
pc_in  input  32  redirect target (bits [1:0] ignored, forced 0)
cpsr_in  input  32  current CPSR; flags N=[31] Z=[30] C=[29] V=[28]
pc_out  output  32  address of instruction in inst (for PC-relative use)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, inst=32'h0, inst_valid=0, imem_req=0, imem_addr=RESET_PC, pc_out=RESET_PC, squash=0.
- States: IDLE, REQ, HOLD.
- IDLE: one cycle after reset release -> REQ with imem_req=1, imem_addr=pc.
- REQ: imem_req=1, imem_addr=pc held stable. On imem_ack and squash=0: inst<=imem_rdata, pc_out<=pc, pc<=pc+PC_STEP, inst_valid<=1 -> HOLD. Data latency: inst visible the cycle after ack.
- HOLD: imem_req=0. If decode_ready: inst_valid<=0, immediately re-request -> REQ (imem_req=1 next cycle, imem_addr=pc). Else hold inst, inst_valid, pc_out unchanged.
- Redirect (pc_we=1), highest priority:
  - in HOLD or IDLE: inst_valid<=0, pc<={pc_in[31:2],2'b00}, -> REQ.
  - in REQ without ack: transaction cannot be abandoned; set squash=1, pc<=target, stay REQ with imem_addr unchanged until ack; on ack discard rdata, clear squash, re-request at new pc (imem_req drops for one cycle).
  - in REQ with simultaneous ack: rdata discarded, pc<=target, -> REQ next cycle with new address after one idle cycle.
  - multiple redirects while squash: last target wins.
- pc_we and decode_ready same cycle in HOLD: redirect wins; current inst counts as consumed.
- PC wraps modulo 2^32 (0xFFFF_FFFC + 4 = 0).
- cond_pass: combinational from inst[31:28] and current cpsr_in flags, ANDed with inst_valid. EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 4'hF (NV) 0.
- imem_req never asserted in HOLD; at most one outstanding request.
- rst_n assertion mid-transaction: all state cleared immediately; a late imem_ack after reset release while in IDLE is ignored.

Test Plan:
- Reset release, memory acks after 2 cycles with 32'hE2011002 at addr 0, decode_ready=1 -> imem_addr=0, inst=E2011002, inst_valid=1, cond_pass=1, pc_out=0; next fetch addr=4.
- inst=32'h02011002 (EQ), cpsr_in[30]=0 then 1 -> cond_pass 0 then 1 combinationally; inst 32'hF2011002 -> cond_pass 0 for any flags.
- decode_ready=0 for 5 cycles in HOLD -> inst, pc_out stable, imem_req=0 throughout; on decode_ready=1 next request at addr 8.
- pc_we=1, pc_in=32'h0000_0103 while REQ pending (ack 3 cycles later, rdata 32'hDEADBEEF) -> DEADBEEF never shows with inst_valid=1; next request addr=32'h100.
- pc_we with simultaneous imem_ack, and pc_we+decode_ready same cycle in HOLD -> data dropped, next imem_addr=target, inst_valid=0 in between.
- pc at 32'hFFFF_FFFC fetched -> next imem_addr=0; rst_n pulsed low mid-REQ -> all outputs at reset values asynchronously, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/arm_fetch.sv
// arm_fetch: instruction fetch stage feeding arm_decode.
//
// Owns the program counter, issues one word read at a time to instruction
// memory over a req/ack handshake, and holds the fetched word until decode
// takes it. It also evaluates the instruction's condition field against the
// live CPSR flags.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   imem_req/imem_addr    fetch request and word address (held until ack)
//   imem_ack/imem_rdata   one-cycle completion pulse and fetched word
//   inst/inst_valid       held instruction and its live flag
//   cond_pass             condition result for inst, 0 when inst_valid=0
//   decode_ready          decode consumes inst this cycle
//   pc_we/pc_in           redirect request and target (low two bits ignored)
//   cpsr_in               current CPSR, flags N,Z,C,V in bits [31:28]
//   pc_out                address of the instruction held in inst
module arm_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        cond_pass,
  input  logic        decode_ready,
  input  logic        pc_we,
  input  logic [31:0] pc_in,
  input  logic [31:0] cpsr_in,
  output logic [31:0] pc_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic [31:0] inst_q;
  logic [31:0] pc_out_q;
  logic        req_q;
  logic        vld_q;
  logic        squash_q;

  logic [31:0] redir_pc_d;
  logic [31:0] pc_seq_d;
  logic        unused_bits;

  assign redir_pc_d  = {pc_in[31:2], 2'b00};
  assign pc_seq_d    = pc_q + PC_STEP;   // wraps modulo 2^32
  assign unused_bits = ^{cpsr_in[27:0], pc_in[1:0]};

  // ARM condition evaluation; nzcv = {N, Z, C, V}.
  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] nzcv);
    logic n, z, cf, v;
    logic r;
    {n, z, cf, v} = nzcv;
    r = 1'b0;
    case (c)
      4'h0: r = z;
      4'h1: r = !z;
      4'h2: r = cf;
      4'h3: r = !cf;
      4'h4: r = n;
      4'h5: r = !n;
      4'h6: r = v;
      4'h7: r = !v;
      4'h8: r = cf && !z;
      4'h9: r = !cf || z;
      4'hA: r = (n == v);
      4'hB: r = (n != v);
      4'hC: r = !z && (n == v);
      4'hD: r = z || (n != v);
      4'hE: r = 1'b1;
      default: r = 1'b0;  // NV: never executes
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      inst_q   <= 32'h0;
      pc_out_q <= RESET_PC;
      req_q    <= 1'b0;
      vld_q    <= 1'b0;
      squash_q <= 1'b0;
    end else begin
      case (state_q)
        // IDLE: single dead cycle after reset or after a dropped response.
        // Any ack seen here belongs to an abandoned transaction and is ignored.
        S_IDLE: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
          vld_q   <= 1'b0;
          if (pc_we) begin
            pc_q   <= redir_pc_d;
            addr_q <= redir_pc_d;
          end else begin
            addr_q <= pc_q;
          end
        end

        // REQ: address must stay put until the memory answers, so a redirect
        // here only retargets pc and marks the in-flight word for discard.
        S_REQ: begin
          if (imem_ack) begin
            req_q    <= 1'b0;
            squash_q <= 1'b0;
            if (pc_we) begin
              pc_q    <= redir_pc_d;
              state_q <= S_IDLE;
            end else if (squash_q) begin
              state_q <= S_IDLE;
            end else begin
              inst_q   <= imem_rdata;
              pc_out_q <= pc_q;
              pc_q     <= pc_seq_d;
              vld_q    <= 1'b1;
              state_q  <= S_HOLD;
            end
          end else if (pc_we) begin
            squash_q <= 1'b1;
            pc_q     <= redir_pc_d;
          end
        end

        // HOLD: no request outstanding; a redirect also retires the held
        // instruction, so it takes priority over decode_ready.
        S_HOLD: begin
          if (pc_we) begin
            vld_q   <= 1'b0;
            pc_q    <= redir_pc_d;
            addr_q  <= redir_pc_d;
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end else if (decode_ready) begin
            vld_q   <= 1'b0;
            addr_q  <= pc_q;
            req_q   <= 1'b1;
            state_q <= S_REQ;
          end
        end

        default: begin
          state_q  <= S_IDLE;
          req_q    <= 1'b0;
          vld_q    <= 1'b0;
          squash_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign inst       = inst_q;
  assign inst_valid = vld_q;
  assign pc_out     = pc_out_q;
  assign cond_pass  = vld_q & eval_cond(inst_q[31:28], cpsr_in[31:28]);

endmodule

// File: tb/tb_arm_fetch.sv
// Self-checking bench for arm_fetch: directed sequences for the fetch,
// hold, redirect, wrap and reset corner cases, a table of condition-code
// vectors, then a randomized run against a transaction-level reference model.
module tb_arm_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic        cond_pass;
  logic        decode_ready;
  logic        pc_we;
  logic [31:0] pc_in;
  logic [31:0] cpsr_in;
  logic [31:0] pc_out;

  int nchk = 0;
  int nerr = 0;

  typedef struct {
    logic [3:0] cond;
    logic [3:0] nzcv;
    logic       exp;
  } cvec_t;

  cvec_t tbl[$];

  arm_fetch #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .cond_pass    (cond_pass),
    .decode_ready (decode_ready),
    .pc_we        (pc_we),
    .pc_in        (pc_in),
    .cpsr_in      (cpsr_in),
    .pc_out       (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference condition evaluation, following the ARM encoding: bits [3:1]
  // pick a predicate, bit 0 inverts it, 4'hF never passes.
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  // Memory contents used by the random run: a scrambled function of address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] w);
    imem_ack   = 1'b1;
    imem_rdata = w;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
  endtask

  task automatic consume();
    decode_ready = 1'b1;
    tick();
    decode_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic [31:0] tgt;
    logic [31:0] rd;
    logic        prev_req, prev_ack, dr, we, ack;
    int          wait_cnt;
    int          ndeliv;

    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; decode_ready = 1'b0;
    pc_we = 1'b0; pc_in = 32'h0; cpsr_in = 32'h0;

    tbl.push_back('{4'h0, 4'b0100, 1'b1});
    tbl.push_back('{4'h0, 4'b0000, 1'b0});
    tbl.push_back('{4'h1, 4'b0000, 1'b1});
    tbl.push_back('{4'h2, 4'b0010, 1'b1});
    tbl.push_back('{4'h3, 4'b0010, 1'b0});
    tbl.push_back('{4'h4, 4'b1000, 1'b1});
    tbl.push_back('{4'h5, 4'b1000, 1'b0});
    tbl.push_back('{4'h6, 4'b0001, 1'b1});
    tbl.push_back('{4'h7, 4'b0000, 1'b1});
    tbl.push_back('{4'h8, 4'b0010, 1'b1});
    tbl.push_back('{4'h8, 4'b0110, 1'b0});
    tbl.push_back('{4'h9, 4'b0110, 1'b1});
    tbl.push_back('{4'h9, 4'b0010, 1'b0});
    tbl.push_back('{4'hA, 4'b1001, 1'b1});
    tbl.push_back('{4'hB, 4'b1000, 1'b1});
    tbl.push_back('{4'hC, 4'b0000, 1'b1});
    tbl.push_back('{4'hC, 4'b1000, 1'b0});
    tbl.push_back('{4'hD, 4'b0100, 1'b1});
    tbl.push_back('{4'hD, 4'b1001, 1'b0});
    tbl.push_back('{4'hE, 4'b1111, 1'b1});
    tbl.push_back('{4'hF, 4'b1111, 1'b0});

    // Reset values
    @(negedge clk);
    chkb("rst_req", imem_req, 1'b0);
    chk ("rst_addr", imem_addr, 32'h0);
    chk ("rst_inst", inst, 32'h0);
    chkb("rst_valid", inst_valid, 1'b0);
    chkb("rst_cond", cond_pass, 1'b0);
    chk ("rst_pc_out", pc_out, 32'h0);
    rst_n = 1'b1;

    // First fetch at address 0, ack two cycles in
    tick();
    chkb("f0_req", imem_req, 1'b1);
    chk ("f0_addr", imem_addr, 32'h0);
    tick();
    chkb("f0_req_held", imem_req, 1'b1);
    fetch(32'hE201_1002);
    chk ("f0_inst", inst, 32'hE201_1002);
    chkb("f0_valid", inst_valid, 1'b1);
    chkb("f0_cond", cond_pass, 1'b1);
    chk ("f0_pc_out", pc_out, 32'h0);
    chkb("f0_req_hold", imem_req, 1'b0);
    consume();
    chk ("f1_addr", imem_addr, 32'h4);
    chkb("f1_valid", inst_valid, 1'b0);

    // EQ condition follows cpsr Z combinationally
    fetch(32'h0201_1002);
    cpsr_in = 32'h0; #1;
    chkb("eq_z0", cond_pass, 1'b0);
    cpsr_in = 32'h4000_0000; #1;
    chkb("eq_z1", cond_pass, 1'b1);

    // Decode stalls for five cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk ("stall_inst", inst, 32'h0201_1002);
      chk ("stall_pc_out", pc_out, 32'h4);
      chkb("stall_req", imem_req, 1'b0);
      chkb("stall_valid", inst_valid, 1'b1);
    end
    consume();
    chk ("f2_addr", imem_addr, 32'h8);
    chkb("f2_req", imem_req, 1'b1);

    // NV never passes
    fetch(32'hF201_1002);
    for (int i = 0; i < 4; i++) begin
      cpsr_in = $urandom; #1;
      chkb("nv_cond", cond_pass, 1'b0);
    end

    // Condition-code table
    for (int i = 0; i < tbl.size(); i++) begin
      consume();
      chk("tbl_addr", imem_addr, 32'd12 + 32'(4 * i));
      fetch({tbl[i].cond, 28'h201_1002});
      cpsr_in = {tbl[i].nzcv, 28'h0}; #1;
      chkb("tbl_cond", cond_pass, tbl[i].exp);
    end

    // Redirect while a request is pending
    consume();
    a = imem_addr;
    pc_we = 1'b1; pc_in = 32'h0000_0103;
    tick();
    pc_we = 1'b0;
    chkb("sq_req", imem_req, 1'b1);
    chk ("sq_addr", imem_addr, a);
    chkb("sq_valid0", inst_valid, 1'b0);
    tick();
    chkb("sq_valid1", inst_valid, 1'b0);
    fetch(32'hDEAD_BEEF);
    chkb("sq_valid2", inst_valid, 1'b0);
    chkb("sq_req_drop", imem_req, 1'b0);
    tick();
    chkb("sq_valid3", inst_valid, 1'b0);
    chkb("sq_rereq", imem_req, 1'b1);
    chk ("sq_new_addr", imem_addr, 32'h100);
    fetch(32'h1111_0000);
    chk ("sq_inst", inst, 32'h1111_0000);
    chk ("sq_pc_out", pc_out, 32'h100);

    // Redirect coinciding with ack
    consume();
    chk("ra_addr", imem_addr, 32'h104);
    imem_ack = 1'b1; imem_rdata = 32'hBADC_0DE0; pc_we = 1'b1; pc_in = 32'h200;
    tick();
    imem_ack = 1'b0; pc_we = 1'b0;
    chkb("ra_valid", inst_valid, 1'b0);
    chkb("ra_req_drop", imem_req, 1'b0);
    tick();
    chkb("ra_req", imem_req, 1'b1);
    chk ("ra_addr2", imem_addr, 32'h200);
    fetch(32'h2222_0000);
    chk ("ra_pc_out", pc_out, 32'h200);

    // Redirect and decode_ready together in HOLD
    decode_ready = 1'b1; pc_we = 1'b1; pc_in = 32'h301;
    tick();
    decode_ready = 1'b0; pc_we = 1'b0;
    chkb("rh_valid", inst_valid, 1'b0);
    chkb("rh_req", imem_req, 1'b1);
    chk ("rh_addr", imem_addr, 32'h300);
    fetch(32'h3333_0000);
    chk ("rh_pc_out", pc_out, 32'h300);

    // PC wrap
    pc_we = 1'b1; pc_in = 32'hFFFF_FFFC;
    tick();
    pc_we = 1'b0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    fetch(32'h4444_0000);
    chk("wr_pc_out", pc_out, 32'hFFFF_FFFC);
    consume();
    chk("wr_next", imem_addr, 32'h0);

    // Asynchronous reset mid-request, then a late ack
    fetch(32'h5555_0000);
    consume();
    chk("ar_pre_addr", imem_addr, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    chkb("ar_req", imem_req, 1'b0);
    chk ("ar_addr", imem_addr, 32'h0);
    chk ("ar_inst", inst, 32'h0);
    chkb("ar_valid", inst_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_0001;
    tick();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    chkb("ar_late_valid", inst_valid, 1'b0);
    chkb("ar_restart_req", imem_req, 1'b1);
    chk ("ar_restart_addr", imem_addr, 32'h0);
    fetch(32'h6666_0000);
    chk ("ar_inst2", inst, 32'h6666_0000);
    chk ("ar_pc_out2", pc_out, 32'h0);

    // Randomized run against the reference model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_pc = 32'h0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0;
    wait_cnt = 1; ndeliv = 0;
    for (int c = 0; c < 3000; c++) begin
      chkb("no_req_in_hold", imem_req & inst_valid, 1'b0);
      chk ("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
      if (prev_req && !prev_ack) begin
        chkb("req_held", imem_req, 1'b1);
        chk ("addr_stable", imem_addr, prev_addr);
      end
      dr = 1'($urandom_range(0, 1));
      we = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else tgt = $urandom;
      ack = 1'b0; rd = 32'h0;
      if (imem_req) begin
        if (wait_cnt == 0) begin
          ack = 1'b1;
          rd = memf(imem_addr);
          wait_cnt = $urandom_range(0, 3);
        end else begin
          wait_cnt--;
        end
      end
      if (inst_valid && dr && !we) begin
        chk("rnd_pc_out", pc_out, exp_pc);
        chk("rnd_inst", inst, memf(exp_pc));
        exp_pc = exp_pc + 32'd4;
        ndeliv++;
      end
      if (we) exp_pc = {tgt[31:2], 2'b00};
      decode_ready = dr; pc_we = we; pc_in = tgt;
      imem_ack = ack; imem_rdata = rd; cpsr_in = $urandom;
      #1;
      chkb("rnd_cond", cond_pass, inst_valid & cond_model(inst[31:28], cpsr_in[31:28]));
      prev_req = imem_req; prev_ack = ack; prev_addr = imem_addr;
      tick();
    end
    imem_ack = 1'b0; decode_ready = 1'b0; pc_we = 1'b0;
    chkb("rnd_progress", ndeliv > 100, 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
